// File: rtl/pipe_mw_skid.sv
// MEM-to-WB valid/ready pipeline stage with a two-entry skid buffer (main + skid).
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_MW_PERF_EN is defined.
module pipe_mw_skid #(
  parameter int unsigned ALU_W  = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned RH_W   = 8,
  parameter int unsigned RN_W   = 3,
  parameter int unsigned PERF_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_m,
  output logic                    ready_m,
  input  logic                    flush_w,
  input  logic [4:0]              ctrl_m,
  input  logic [LANES-1:0]        lane_mask_m,
  input  logic [ALU_W-1:0]        alu_m,
  input  logic [LANES*LANE_W-1:0] mem_data_m,
  input  logic [LANES*LANE_W-1:0] lanes_m,
  input  logic [RH_W-1:0]         rhd_m,
  input  logic                    rvd_m,
  input  logic [RN_W-1:0]         rnd_m,
  output logic                    valid_w,
  input  logic                    ready_w,
  output logic [4:0]              ctrl_w,
  output logic [LANES-1:0]        lane_we_w,
  output logic [ALU_W-1:0]        alu_w,
  output logic [LANES*LANE_W-1:0] mem_data_w,
  output logic [LANES*LANE_W-1:0] lanes_w,
  output logic [RH_W-1:0]         rhd_w,
  output logic                    rvd_w,
  output logic [RN_W-1:0]         rnd_w,
  output logic [ALU_W-1:0]        wb_scalar_w
`ifdef PIPE_MW_PERF_EN
  ,
  output logic [PERF_W-1:0]       stall_cnt,
  output logic [PERF_W-1:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ctrl = {PCSrc, ScalarWrite, VectorWrite, HistogramWrite, MemtoReg}
  typedef struct packed {
    logic [4:0]              ctrl;
    logic [LANES-1:0]        mask;
    logic [ALU_W-1:0]        alu;
    logic [LANES*LANE_W-1:0] mem;
    logic [LANES*LANE_W-1:0] lanes;
    logic [RH_W-1:0]         rhd;
    logic                    rvd;
    logic [RN_W-1:0]         rnd;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_e;
  logic   ready_q, ready_d;
  logic   accept, consume;

  assign in_e    = '{ctrl: ctrl_m, mask: lane_mask_m, alu: alu_m, mem: mem_data_m,
                     lanes: lanes_m, rhd: rhd_m, rvd: rvd_m, rnd: rnd_m};
  assign valid_w = (state_q != EMPTY);
  assign ready_m = ready_q;
  assign accept  = valid_m & ready_q;
  assign consume = valid_w & ready_w;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_w) begin
      // Handshake still completes on an accept; the entry is simply dropped.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_e;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_e;
          end else if (accept) begin
            skid_d  = in_e;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign ctrl_w      = main_q.ctrl & {5{valid_w}};
  assign lane_we_w   = main_q.mask & {LANES{main_q.ctrl[2]}} & {LANES{valid_w}};
  assign alu_w       = main_q.alu;
  assign mem_data_w  = main_q.mem;
  assign lanes_w     = main_q.lanes;
  assign rhd_w       = main_q.rhd;
  assign rvd_w       = main_q.rvd;
  assign rnd_w       = main_q.rnd;
  assign wb_scalar_w = main_q.ctrl[0] ? main_q.mem[ALU_W-1:0] : main_q.alu;

`ifdef PIPE_MW_PERF_EN
  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (valid_m && !ready_q && (stall_q != '1))
      stall_d = stall_q + 1'b1;
    if (flush_w && (valid_w || accept) && (flush_q != '1))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_perf;
  assign unused_perf = ^PERF_W;
`endif

endmodule
